// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Converts a MEM-stage load/store into one valid/ready bus request and waits
// for its single response. Drives mem_stall to the hazard unit until the load
// data is registered. A switch_mode kill lets any in-flight bus transaction
// finish, then discards its response.
module dmem_access_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rstn,

    // MEM-stage request
    input  logic                mem_req_valid,
    input  logic                mem_we,
    input  logic [XLEN-1:0]     mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN/8-1:0]   mem_wmask,
    input  logic                switch_mode,

    // MEM-stage response / hazard interface
    output logic                mem_stall,
    output logic [XLEN-1:0]     mem_rdata,
    output logic                mem_rdata_valid,
    output logic                mem_fault,

    // Data bus request channel
    output logic                bus_req_valid,
    input  logic                bus_req_ready,
    output logic                bus_req_we,
    output logic [XLEN-1:0]     bus_req_addr,
    output logic [XLEN-1:0]     bus_req_wdata,
    output logic [XLEN/8-1:0]   bus_req_wmask,

    // Data bus response channel
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata,
    input  logic                bus_rerr,

    // Performance counter
    output logic [CNT_W-1:0]    stall_cycles
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state;

    // Set when the instruction owning an unaccepted request is flushed; the
    // request must still complete its handshake, but its response is dropped.
    logic   killed;

    logic   req_accept;

    assign req_accept = bus_req_valid & bus_req_ready;

    // Combinational so the hazard unit sees the stall in the request's first
    // cycle; released only in DONE, where the pipeline is allowed to advance.
    assign mem_stall = mem_req_valid & ~switch_mode & (state != DONE);

    // Access FSM with registered bus request, payload and response outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            killed          <= 1'b0;
            bus_req_valid   <= 1'b0;
            bus_req_we      <= 1'b0;
            bus_req_addr    <= '0;
            bus_req_wdata   <= '0;
            bus_req_wmask   <= '0;
            mem_rdata       <= '0;
            mem_rdata_valid <= 1'b0;
            mem_fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_valid && !switch_mode) begin
                        bus_req_we    <= mem_we;
                        bus_req_addr  <= mem_addr;
                        bus_req_wdata <= mem_wdata;
                        bus_req_wmask <= mem_wmask;
                        bus_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end

                REQ: begin
                    // Valid stays asserted until accepted, even after a kill,
                    // so the bus never sees a withdrawn request.
                    if (req_accept) begin
                        bus_req_valid <= 1'b0;
                        if (killed || switch_mode) begin
                            state <= DRAIN;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (switch_mode) begin
                        killed <= 1'b1;
                    end
                end

                WAIT: begin
                    if (switch_mode) begin
                        // Response arriving with the kill is simply dropped;
                        // otherwise it is still owed and must be drained.
                        if (bus_rvalid) begin
                            killed <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state  <= DRAIN;
                        end
                    end else if (bus_rvalid) begin
                        if (killed) begin
                            killed <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            mem_rdata       <= bus_rdata;
                            mem_fault       <= bus_rerr;
                            mem_rdata_valid <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end

                DRAIN: begin
                    // New requests wait for IDLE; only the owed response
                    // is consumed here, with no result reported upstream.
                    if (bus_rvalid) begin
                        killed <= 1'b0;
                        state  <= IDLE;
                    end
                end

                DONE: begin
                    mem_rdata_valid <= 1'b0;
                    mem_fault       <= 1'b0;
                    state           <= IDLE;
                end

                default: begin
                    bus_req_valid   <= 1'b0;
                    mem_rdata_valid <= 1'b0;
                    mem_fault       <= 1'b0;
                    killed          <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (mem_stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl. Two instances share all inputs:
// one with the default 32-bit stall counter and one with a 4-bit counter so
// saturation is reached during the normal directed sequence.
module tb_dmem_access_ctrl;

    localparam int XLEN = 32;

    logic            clk;
    logic            rstn;
    logic            mem_req_valid;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wmask;
    logic            switch_mode;
    logic            bus_req_ready;
    logic            bus_rvalid;
    logic [31:0]     bus_rdata;
    logic            bus_rerr;

    logic            mem_stall;
    logic [31:0]     mem_rdata;
    logic            mem_rdata_valid;
    logic            mem_fault;
    logic            bus_req_valid;
    logic            bus_req_we;
    logic [31:0]     bus_req_addr;
    logic [31:0]     bus_req_wdata;
    logic [3:0]      bus_req_wmask;
    logic [31:0]     stall_cycles;

    logic            s_mem_stall;
    logic [31:0]     s_mem_rdata;
    logic            s_mem_rdata_valid;
    logic            s_mem_fault;
    logic            s_bus_req_valid;
    logic            s_bus_req_we;
    logic [31:0]     s_bus_req_addr;
    logic [31:0]     s_bus_req_wdata;
    logic [3:0]      s_bus_req_wmask;
    logic [3:0]      s_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_access_ctrl #(.XLEN(XLEN), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .switch_mode(switch_mode),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_fault(mem_fault),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rerr(bus_rerr),
        .stall_cycles(stall_cycles)
    );

    dmem_access_ctrl #(.XLEN(XLEN), .CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .switch_mode(switch_mode),
        .mem_stall(s_mem_stall), .mem_rdata(s_mem_rdata),
        .mem_rdata_valid(s_mem_rdata_valid), .mem_fault(s_mem_fault),
        .bus_req_valid(s_bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(s_bus_req_we), .bus_req_addr(s_bus_req_addr),
        .bus_req_wdata(s_bus_req_wdata), .bus_req_wmask(s_bus_req_wmask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rerr(bus_rerr),
        .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn          = 1'b0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wmask     = '0;
        switch_mode   = 1'b0;
        bus_req_ready = 1'b0;
        bus_rvalid    = 1'b0;
        bus_rdata     = '0;
        bus_rerr      = 1'b0;

        // ---- reset state ----
        tick(); tick();
        #1;
        chk("rst_stall",      mem_stall, 0);
        chk("rst_req_valid",  bus_req_valid, 0);
        chk("rst_rdata",      mem_rdata, 0);
        chk("rst_rdata_vld",  mem_rdata_valid, 0);
        chk("rst_fault",      mem_fault, 0);
        chk("rst_addr",       bus_req_addr, 0);
        chk("rst_cnt",        stall_cycles, 0);
        tick();
        rstn = 1'b1;
        tick();

        // ---- 1: minimum-latency load ----
        mem_req_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_1000;
        #1;
        chk("ld_c0_stall",    mem_stall, 1);
        chk("ld_c0_reqv",     bus_req_valid, 0);
        tick();
        bus_req_ready = 1'b1;
        #1;
        chk("ld_c1_stall",    mem_stall, 1);
        chk("ld_c1_reqv",     bus_req_valid, 1);
        chk("ld_c1_addr",     bus_req_addr, 32'h0000_1000);
        chk("ld_c1_we",       bus_req_we, 0);
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_c2_stall",    mem_stall, 1);
        chk("ld_c2_reqv",     bus_req_valid, 0);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("ld_c3_stall",    mem_stall, 0);
        chk("ld_c3_rvld",     mem_rdata_valid, 1);
        chk("ld_c3_rdata",    mem_rdata, 32'hDEAD_BEEF);
        chk("ld_c3_fault",    mem_fault, 0);
        chk("ld_c3_cnt",      stall_cycles, 3);
        chk("ld_c3_cnt4",     s_stall_cycles, 3);
        tick();
        mem_req_valid = 1'b0;
        #1;
        chk("ld_c4_rvld",     mem_rdata_valid, 0);
        chk("ld_c4_stall",    mem_stall, 0);
        tick();

        // ---- 2: store with ready held low for four cycles ----
        mem_req_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h20;
        mem_wdata = 32'h1234_5678; mem_wmask = 4'hF;
        #1;
        chk("st_c0_stall",    mem_stall, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) bus_req_ready = 1'b1;
            #1;
            chk("st_reqv",    bus_req_valid, 1);
            chk("st_we",      bus_req_we, 1);
            chk("st_addr",    bus_req_addr, 32'h20);
            chk("st_wdata",   bus_req_wdata, 32'h1234_5678);
            chk("st_wmask",   bus_req_wmask, 4'hF);
            chk("st_stall",   mem_stall, 1);
        end
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0; bus_rerr = 1'b0;
        #1;
        chk("st_wait_reqv",   bus_req_valid, 0);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("st_done_rvld",   mem_rdata_valid, 1);
        chk("st_done_fault",  mem_fault, 0);
        chk("st_done_stall",  mem_stall, 0);
        chk("st_done_cnt",    stall_cycles, 10);
        chk("st_done_cnt4",   s_stall_cycles, 10);
        tick();
        mem_req_valid = 1'b0; mem_we = 1'b0;
        tick();

        // ---- 3: kill in WAIT, late response drained ----
        mem_req_valid = 1'b1; mem_addr = 32'h40;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0; switch_mode = 1'b1;
        #1;
        chk("kw_stall_kill",  mem_stall, 0);
        tick();
        switch_mode = 1'b0; mem_req_valid = 1'b0;
        #1;
        chk("kw_d1_reqv",     bus_req_valid, 0);
        chk("kw_d1_rvld",     mem_rdata_valid, 0);
        tick();
        mem_req_valid = 1'b1; mem_addr = 32'h80;
        #1;
        chk("kw_d2_stall",    mem_stall, 1);
        tick();
        bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_5555;
        #1;
        chk("kw_d3_reqv",     bus_req_valid, 0);
        chk("kw_d3_rvld",     mem_rdata_valid, 0);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("kw_idle_rvld",   mem_rdata_valid, 0);
        chk("kw_idle_fault",  mem_fault, 0);
        chk("kw_idle_reqv",   bus_req_valid, 0);
        chk("kw_idle_rdata",  mem_rdata, 32'h0);
        tick();
        bus_req_ready = 1'b1;
        #1;
        chk("kw_new_reqv",    bus_req_valid, 1);
        chk("kw_new_addr",    bus_req_addr, 32'h80);
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("kw_new_rvld",    mem_rdata_valid, 1);
        chk("kw_new_rdata",   mem_rdata, 32'h1111_2222);
        chk("sat_cnt4_a",     s_stall_cycles, 15);
        tick();
        mem_req_valid = 1'b0;
        tick();

        // ---- 4: kill in REQ with ready low ----
        mem_req_valid = 1'b1; mem_addr = 32'h100;
        tick();
        switch_mode = 1'b1;
        #1;
        chk("kr_reqv",        bus_req_valid, 1);
        chk("kr_stall",       mem_stall, 0);
        tick();
        switch_mode = 1'b0; mem_req_valid = 1'b0;
        #1;
        chk("kr_hold1",       bus_req_valid, 1);
        chk("kr_hold_addr",   bus_req_addr, 32'h100);
        tick();
        bus_req_ready = 1'b1;
        #1;
        chk("kr_hold2",       bus_req_valid, 1);
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        #1;
        chk("kr_drain_reqv",  bus_req_valid, 0);
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("kr_idle_rvld",   mem_rdata_valid, 0);
        chk("kr_idle_rdata",  mem_rdata, 32'h1111_2222);
        tick();

        // ---- 5: load with bus error ----
        mem_req_valid = 1'b1; mem_addr = 32'h200;
        tick();
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rerr = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_rvalid = 1'b0; bus_rerr = 1'b0;
        #1;
        chk("err_fault",      mem_fault, 1);
        chk("err_rvld",       mem_rdata_valid, 1);
        chk("err_rdata",      mem_rdata, 32'hBAD0_BAD0);
        tick();
        mem_req_valid = 1'b0;
        #1;
        chk("err_fault_off",  mem_fault, 0);
        chk("err_rvld_off",   mem_rdata_valid, 0);
        tick();

        // ---- 6: 20 stall cycles, saturation, then reset mid-WAIT ----
        mem_req_valid = 1'b1; mem_addr = 32'h300;
        mem_wdata = 32'hCAFE_F00D; mem_wmask = 4'h3;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        #1;
        chk("sat_reqv",       bus_req_valid, 1);
        chk("sat_wdata",      bus_req_wdata, 32'hCAFE_F00D);
        chk("sat_cnt4_b",     s_stall_cycles, 15);
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        #1;
        chk("rw_wait_reqv",   bus_req_valid, 0);
        #1;
        rstn = 1'b0; mem_req_valid = 1'b0;
        #1;
        chk("rw_stall",       mem_stall, 0);
        chk("rw_reqv",        bus_req_valid, 0);
        chk("rw_addr",        bus_req_addr, 0);
        chk("rw_wdata",       bus_req_wdata, 0);
        chk("rw_wmask",       bus_req_wmask, 0);
        chk("rw_rdata",       mem_rdata, 0);
        chk("rw_rvld",        mem_rdata_valid, 0);
        chk("rw_fault",       mem_fault, 0);
        chk("rw_cnt",         stall_cycles, 0);
        chk("rw_cnt4",        s_stall_cycles, 0);
        tick();
        rstn = 1'b1;
        tick();

        // ---- 7: fresh transaction after reset starts from IDLE ----
        mem_req_valid = 1'b1; mem_addr = 32'h400;
        #1;
        chk("pr_c0_reqv",     bus_req_valid, 0);
        tick();
        bus_req_ready = 1'b1;
        #1;
        chk("pr_c1_reqv",     bus_req_valid, 1);
        chk("pr_c1_addr",     bus_req_addr, 32'h400);
        tick();
        bus_req_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_rvalid = 1'b0;
        #1;
        chk("pr_c3_rvld",     mem_rdata_valid, 1);
        chk("pr_c3_rdata",    mem_rdata, 32'h0BAD_F00D);
        chk("pr_c3_cnt",      stall_cycles, 3);
        chk("pr_c3_cnt4",     s_stall_cycles, 3);
        tick();
        mem_req_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
